// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with debounced per-channel inc/dec duty buttons and shadow/active duty.
// Define PWM_CENTER_ALIGNED_EN to compile in the center-aligned up/down counter and mode register.
module pwm_multi_channel #(
    parameter int CH       = 4,
    parameter int PERIOD   = 10,
    parameter int CNT_W    = 8,
    parameter int DEB_DIV  = 2,
    parameter int DUTY_RST = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       inc,
    input  logic [CH-1:0]       dec,
    input  logic                center,
    output logic [CH-1:0]       pwm_out,
    output logic [CH*CNT_W-1:0] duty,
    output logic                period_start
);

    localparam int               DW       = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] P_FULL   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] D_RST    = CNT_W'(DUTY_RST);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [DW-1:0]    deb_cnt_reg;
    logic             tick;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             wrap;

    assign tick = (deb_cnt_reg == DEB_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            deb_cnt_reg <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    logic down_reg, down_next;
    logic center_mode_reg;

    // Down leg runs PERIOD-2..1; with PERIOD==2 the down leg is empty.
    always_comb begin
        cnt_next  = cnt_reg + 1'b1;
        down_next = down_reg;
        wrap      = 1'b0;
        if (down_reg) begin
            if (cnt_reg <= C_ONE) begin
                cnt_next  = '0;
                down_next = 1'b0;
                wrap      = 1'b1;
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
        end else if (cnt_reg == P_LAST) begin
            if (center_mode_reg && (PERIOD > 2)) begin
                cnt_next  = P_LAST - 1'b1;
                down_next = 1'b1;
            end else begin
                cnt_next = '0;
                wrap     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg         <= '0;
            down_reg        <= 1'b0;
            center_mode_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            down_reg <= down_next;
            if (wrap) begin
                center_mode_reg <= center;
            end
        end
    end

    assign period_start = (cnt_reg == '0) && !down_reg;
`else
    logic unused_center;
    assign unused_center = center;

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        wrap     = 1'b0;
        if (cnt_reg == P_LAST) begin
            cnt_next = '0;
            wrap     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign period_start = (cnt_reg == '0);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            // Bit 0 is s1, bit 1 is s2; both advance only on tick.
            logic [1:0]       inc_s_reg, dec_s_reg;
            logic             inc_p, dec_p;
            logic [CNT_W-1:0] shadow_reg, active_reg;
            logic             pwm_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    inc_s_reg <= '0;
                    dec_s_reg <= '0;
                end else if (tick) begin
                    inc_s_reg <= {inc_s_reg[0], inc[gi]};
                    dec_s_reg <= {dec_s_reg[0], dec[gi]};
                end
            end

            assign inc_p = inc_s_reg[0] & ~inc_s_reg[1] & tick;
            assign dec_p = dec_s_reg[0] & ~dec_s_reg[1] & tick;

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= D_RST;
                end else if (inc_p && !dec_p && (shadow_reg != P_FULL)) begin
                    shadow_reg <= shadow_reg + 1'b1;
                end else if (dec_p && !inc_p && (shadow_reg != '0)) begin
                    shadow_reg <= shadow_reg - 1'b1;
                end
            end

            // Active duty only changes at the boundary, so no runt pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    active_reg <= D_RST;
                    pwm_reg    <= 1'b0;
                end else begin
                    if (wrap) begin
                        active_reg <= shadow_reg;
                    end
                    pwm_reg <= (cnt_reg < active_reg);
                end
            end

            assign pwm_out[gi]                = pwm_reg;
            assign duty[gi*CNT_W +: CNT_W]    = shadow_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: period/high-time measurement per period,
// button presses with hand-computed duty values, saturation, reset and mode switching.
module tb_pwm_multi_channel;

    logic        clk;
    logic        rst;
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic        center;
    logic [3:0]  pwm_out;
    logic [31:0] duty;
    logic        period_start;

    int          n_vec;
    int          n_err;
    int          m_len;
    int          m_hi [4];
    logic [39:0] m_pat;

    pwm_multi_channel #(
        .CH(4), .PERIOD(10), .CNT_W(8), .DEB_DIV(2), .DUTY_RST(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inc(inc),
        .dec(dec),
        .center(center),
        .pwm_out(pwm_out),
        .duty(duty),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int duty_of(input int c);
        return int'(duty[c*8 +: 8]);
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
        $display("vector %0d %s: observed %0d expected %0d", n_vec, tag, obs, exp_v);
    endtask

    // Measures one full period starting at a period_start cycle; optionally drives
    // buttons/center at a given step inside the period.
    task automatic measure(input int act_step, input logic [3:0] ai, input logic [3:0] ad,
                           input logic ac);
        int w;
        w = 0;
        while (!period_start && w < 40) begin
            @(negedge clk);
            w++;
        end
        m_len = 0;
        m_pat = '0;
        for (int c = 0; c < 4; c++) m_hi[c] = 0;
        if (!period_start) begin
            check("period_sync", int'(period_start), 1);
            return;
        end
        do begin
            @(negedge clk);
            m_len++;
            for (int c = 0; c < 4; c++) m_hi[c] += int'(pwm_out[c]);
            if (m_len < 40) m_pat[m_len] = pwm_out[0];
            if (m_len == act_step) begin
                inc    = ai;
                dec    = ad;
                center = ac;
            end
        end while (!period_start && m_len < 40);
    endtask

    task automatic press(input logic [3:0] im, input logic [3:0] dm);
        inc = im;
        dec = dm;
        repeat (6) @(negedge clk);
        inc = '0;
        dec = '0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        inc    = '0;
        dec    = '0;
        center = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_duty", int'(duty), 32'h05050505);
        check("rst_period_start", int'(period_start), 1);
        rst = 1'b0;

        measure(-1, '0, '0, 1'b0);
        check("edge_len", m_len, 10);
        for (int c = 0; c < 4; c++) check($sformatf("edge_hi_ch%0d", c), m_hi[c], 5);
        check("edge_pat_ch0", int'(m_pat), 32'h3E);

        // Held inc on ch1 across two periods.
        measure(1, 4'b0010, 4'b0000, 1'b0);
        check("held_cur_len", m_len, 10);
        check("held_cur_hi_ch1", m_hi[1], 5);
        check("held_duty1", duty_of(1), 6);
        measure(-1, 4'b0010, 4'b0000, 1'b0);
        check("held_next_hi_ch1", m_hi[1], 6);
        inc = '0;
        repeat (6) @(negedge clk);
        check("held_once_duty1", duty_of(1), 6);

        // Saturation: ch0 up to full scale, ch2 down to zero.
        repeat (7) press(4'b0001, 4'b0100);
        repeat (5) press(4'b0000, 4'b0100);
        check("sat_duty0", duty_of(0), 10);
        check("sat_duty2", duty_of(2), 0);
        press(4'b0001, 4'b0100);
        check("sat_nowrap_duty0", duty_of(0), 10);
        check("sat_nowrap_duty2", duty_of(2), 0);
        measure(-1, '0, '0, 1'b0);
        check("sat_len", m_len, 10);
        check("sat_hi_ch0", m_hi[0], 10);
        check("sat_hi_ch1", m_hi[1], 6);
        check("sat_hi_ch2", m_hi[2], 0);
        check("sat_hi_ch3", m_hi[3], 5);

        press(4'b1000, 4'b1000);
        check("simul_duty3", duty_of(3), 5);

        for (int k = 0; k < 8; k++) begin
            inc[3] = 1'b1;
            @(negedge clk);
            inc[3] = 1'b0;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("bounce_duty3_step_le1", int'(duty_of(3) == 5 || duty_of(3) == 6), 1);

        // Reset mid-period with ch0 at 8.
        press(4'b0000, 4'b0001);
        press(4'b0000, 4'b0001);
        check("pre_rst_duty0", duty_of(0), 8);
        measure(-1, '0, '0, 1'b0);
        check("pre_rst_hi_ch0", m_hi[0], 8);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pwm_out", int'(pwm_out), 0);
        check("midrst_period_start", int'(period_start), 1);
        check("midrst_duty", int'(duty), 32'h05050505);
        rst = 1'b0;
        measure(-1, '0, '0, 1'b0);
        check("post_rst_len", m_len, 10);
        for (int c = 0; c < 4; c++) check($sformatf("post_rst_hi_ch%0d", c), m_hi[c], 5);

        // center raised mid-period only takes effect at the next boundary.
        measure(3, '0, '0, 1'b1);
        check("center_cur_len", m_len, 10);
        measure(-1, '0, '0, 1'b1);
`ifdef PWM_CENTER_ALIGNED_EN
        check("center_len", m_len, 18);
        check("center_hi_ch0", m_hi[0], 9);
        check("center_hi_ch1", m_hi[1], 9);
        check("center_pat_ch0", int'(m_pat), 32'h7803E);
`else
        check("center_ignored_len", m_len, 10);
        check("center_ignored_hi_ch0", m_hi[0], 5);
        check("center_ignored_pat_ch0", int'(m_pat), 32'h3E);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
